esc_ctrl: RTL and testbench
===========================

# esc_ctrl

Arming, slew-limit and failsafe controller that sits between command sources and the `esc` pulse generator. It runs on the 50 MHz system clock and enforces the standard ESC power-up protocol: hold zero throttle for a fixed arming period before any throttle is passed. It accepts throttle targets over a valid/ready handshake and ramps `cmd` toward the target at a bounded rate. If the command stream stalls, a watchdog forces a controlled ramp to zero. `cmd` drives the `cmd` input of `esc` directly, in place of any raw signal source.

## Interface
- `CMD_BITS`, 10: width of target and command, matching `esc`
- `TICK_DIV`, 50000: clk cycles per control tick (1 ms at 50 MHz)
- `ARM_TICKS`, 2000: ticks of zero throttle required before RUN
- `TIMEOUT_TICKS`, 100: ticks without an accepted target before FAILSAFE
- `STEP`, 4: maximum `cmd` change per tick, in LSBs; must be ≥1

- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  synchronous, active-high reset
- `arm_req`  in  1  level; 1 = request arming/run, 0 = disarm
- `tgt`  in  CMD_BITS  throttle target
- `tgt_valid`  in  1  `tgt` is valid this cycle
- `tgt_ready`  out  1  target accepted when `tgt_valid & tgt_ready`
- `cmd`  out  CMD_BITS  registered throttle command to `esc`
- `armed`  out  1  high only in RUN
- `fault`  out  1  high only in FAILSAFE
- `state`  out  2  0 = DISARMED, 1 = ARMING, 2 = RUN, 3 = FAILSAFE

## Operation
- Tick prescaler:
  - Counts 0..TICK_DIV-1; `tick` pulses for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
  - The count clears to 0 on reset and on the DISARMED→ARMING transition.
- Internal registers:
  - `tgt_r` (CMD_BITS), the accepted target.
  - `tcnt`, the tick counter shared by arming and watchdog, sized to hold max(ARM_TICKS, TIMEOUT_TICKS).
- DISARMED:
  - `cmd`=0, `tgt_r`=0.
  - `arm_req`=1 → ARMING, with `tcnt`=0.
- ARMING:
  - `cmd`=0.
  - `tcnt` increments on each tick.
  - `arm_req`=0 → DISARMED.
  - On the tick where `tcnt` reaches ARM_TICKS-1 → RUN, with `tcnt`=0 and `tgt_r`=0.
- RUN:
  - `tgt_ready`=1. On a handshake, `tgt_r`←`tgt` and `tcnt`←0.
  - On each tick without a handshake, `tcnt` increments.
  - On each tick, `cmd` moves toward `tgt_r` by min(STEP, |`tgt_r`−`cmd`|):
    - the difference is computed at CMD_BITS+1 signed width;
    - `cmd` never overshoots `tgt_r` and never wraps.
  - Timeout: on the tick where `tcnt` reaches TIMEOUT_TICKS-1 with no handshake in that cycle → FAILSAFE.
  - `arm_req`=0 → DISARMED; `cmd`=0 on the next cycle, with no ramp.
- FAILSAFE:
  - `tgt_r`←0; `cmd` ramps down by STEP per tick until it reaches 0.
  - `tgt_valid` is ignored.
  - The state persists until `arm_req`=0 → DISARMED. Re-arming requires a full ARMING period.
- Outputs:
  - `tgt_ready` = (state==RUN), combinational.
  - `armed`, `fault` and `state` decode from the state register.
  - `cmd` is registered.

## Timing
- Reset values: state=DISARMED, `cmd`=0, `tgt_r`=0, `tcnt`=0, prescaler=0; `armed`=0, `fault`=0, `tgt_ready`=0.
- `rst` asserted in any state returns to these values on the next edge. No ramp-down is performed.
- Handshake:
  - One transfer per cycle while `tgt_ready`=1.
  - `tgt` is sampled only on the handshake cycle.
  - There is no back-pressure other than state.
- Latency:
  - A target accepted at cycle n first affects `cmd` at the first tick strictly after n.
  - `cmd` changes on the edge following that tick cycle.
- Handshake and tick in the same cycle:
  - The step for that tick uses the old `tgt_r`.
  - The watchdog clears (`tcnt`←0); the clear has priority over the increment and over timeout.
- `arm_req`=0 coinciding with timeout or the arming completion tick → DISARMED wins.
- Worst-case ramp from full scale: ceil((2^CMD_BITS−1)/STEP) ticks.

## Test plan
Bench parameters: TICK_DIV=4, ARM_TICKS=3, TIMEOUT_TICKS=5, STEP=4.
- Reset then `arm_req`=1:
  - `state`=1 with `cmd`=0 for 3 ticks (12 clk);
  - then `state`=2, `armed`=1, `tgt_ready`=1.
- In RUN, send `tgt`=10, then keep sending `tgt`=10 every 2 ticks:
  - `cmd` steps 4, 8, 10 on successive ticks, then holds at 10;
  - send `tgt`=3: `cmd` goes 6, then 3.
- In RUN at `cmd`=10, stop sending targets:
  - on the 5th tick after the last handshake, `state`=3 and `fault`=1;
  - `cmd` then goes 6, 2, 0; `tgt_ready`=0 throughout;
  - `arm_req`=0 → `state`=0 and `fault`=0.
- Drop `arm_req` in ARMING after 2 ticks → `state`=0. Reassert it → a full 3 ticks are required again.
- Drop `arm_req` in RUN at `cmd`=10 → `cmd`=0 and `state`=0 on the next cycle.
- Assert `rst` mid-ramp in RUN → all outputs reach their reset values one cycle later. Handshake on the same cycle as the timeout tick → state stays RUN and `tcnt`=0.

Source files
------------

// File: rtl/esc_ctrl.sv
// rtl/esc_ctrl.sv - ESC arming, slew-limit and failsafe controller
module esc_ctrl #(
    parameter int CMD_BITS      = 10,
    parameter int TICK_DIV      = 50000,
    parameter int ARM_TICKS     = 2000,
    parameter int TIMEOUT_TICKS = 100,
    parameter int STEP          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm_req,
    input  logic [CMD_BITS-1:0] tgt,
    input  logic                tgt_valid,
    output logic                tgt_ready,
    output logic [CMD_BITS-1:0] cmd,
    output logic                armed,
    output logic                fault,
    output logic [1:0]          state
);
    localparam int MAX_TICKS = (ARM_TICKS > TIMEOUT_TICKS) ? ARM_TICKS : TIMEOUT_TICKS;
    localparam int TW = $clog2(MAX_TICKS + 1);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0]             PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]             ARM_LAST = TW'(ARM_TICKS - 1);
    localparam logic [TW-1:0]             TO_LAST  = TW'(TIMEOUT_TICKS - 1);
    localparam logic signed [CMD_BITS:0]  STEP_S   = (CMD_BITS + 1)'(STEP);
    localparam logic [CMD_BITS-1:0]       STEP_U   = CMD_BITS'(STEP);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMING   = 2'd1,
        S_RUN      = 2'd2,
        S_FAILSAFE = 2'd3
    } state_t;

    state_t                    st;
    logic [PW-1:0]             pcnt;
    logic [TW-1:0]             tcnt;
    logic [CMD_BITS-1:0]       tgt_r;
    logic                      tick;
    logic                      hs;
    logic signed [CMD_BITS:0]  diff;
    logic [CMD_BITS-1:0]       cmd_next;

    // Tick strobe, handshake and the slew-limited next command toward tgt_r
    always_comb begin
        tick = (pcnt == PRE_LAST);
        hs   = tgt_valid && (st == S_RUN);
        diff = $signed({1'b0, tgt_r}) - $signed({1'b0, cmd});
        if (diff > STEP_S) begin
            cmd_next = cmd + STEP_U;
        end else if (diff < -STEP_S) begin
            cmd_next = cmd - STEP_U;
        end else begin
            cmd_next = tgt_r;
        end
    end

    // Controller state machine, prescaler, watchdog/arming counter and command register
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= S_DISARMED;
            cmd   <= '0;
            tgt_r <= '0;
            tcnt  <= '0;
            pcnt  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            case (st)
                S_DISARMED: begin
                    cmd   <= '0;
                    tgt_r <= '0;
                    if (arm_req) begin
                        st   <= S_ARMING;
                        tcnt <= '0;
                        pcnt <= '0;
                    end
                end
                S_ARMING: begin
                    cmd <= '0;
                    if (!arm_req) begin
                        st <= S_DISARMED;
                    end else if (tick) begin
                        if (tcnt == ARM_LAST) begin
                            st    <= S_RUN;
                            tcnt  <= '0;
                            tgt_r <= '0;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (!arm_req) begin
                        st    <= S_DISARMED;
                        cmd   <= '0;
                        tgt_r <= '0;
                    end else begin
                        // the step on a tick uses the target held before any same-cycle handshake
                        if (tick) begin
                            cmd <= cmd_next;
                        end
                        if (hs) begin
                            tgt_r <= tgt;
                            tcnt  <= '0;
                        end else if (tick) begin
                            if (tcnt == TO_LAST) begin
                                st    <= S_FAILSAFE;
                                tgt_r <= '0;
                            end else begin
                                tcnt <= tcnt + TW'(1);
                            end
                        end
                    end
                end
                S_FAILSAFE: begin
                    if (!arm_req) begin
                        st    <= S_DISARMED;
                        cmd   <= '0;
                        tgt_r <= '0;
                    end else if (tick) begin
                        cmd <= cmd_next;
                    end
                end
                default: begin
                    st <= S_DISARMED;
                end
            endcase
        end
    end

    assign tgt_ready = (st == S_RUN);
    assign armed     = (st == S_RUN);
    assign fault     = (st == S_FAILSAFE);
    assign state     = st;

endmodule

// File: tb/tb_esc_ctrl.sv
// tb/tb_esc_ctrl.sv - table, directed and randomized checks for esc_ctrl
module tb_esc_ctrl;
    localparam int CMD_BITS      = 10;
    localparam int TICK_DIV      = 4;
    localparam int ARM_TICKS     = 3;
    localparam int TIMEOUT_TICKS = 5;
    localparam int STEP          = 4;

    logic                clk;
    logic                rst;
    logic                arm_req;
    logic [CMD_BITS-1:0] tgt;
    logic                tgt_valid;
    logic                tgt_ready;
    logic [CMD_BITS-1:0] cmd;
    logic                armed;
    logic                fault;
    logic [1:0]          state;

    int checks = 0;
    int errors = 0;

    // reference model: spec-level bookkeeping in plain integers
    int m_st   = 0;
    int m_cmd  = 0;
    int m_tgt  = 0;
    int m_cyc  = 0;
    int m_ticks = 0;

    esc_ctrl #(
        .CMD_BITS(CMD_BITS),
        .TICK_DIV(TICK_DIV),
        .ARM_TICKS(ARM_TICKS),
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .STEP(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arm_req(arm_req),
        .tgt(tgt),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .cmd(cmd),
        .armed(armed),
        .fault(fault),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp_step(input int d);
        if (d > STEP) return STEP;
        if (d < -STEP) return -STEP;
        return d;
    endfunction

    // advance the model by one clock edge given the inputs seen at that edge
    task automatic model_step(input bit r, input bit a, input bit v, input int t);
        bit is_tick;
        int n_cyc;
        if (r) begin
            m_st = 0; m_cmd = 0; m_tgt = 0; m_cyc = 0; m_ticks = 0;
            return;
        end
        is_tick = ((m_cyc + 1) % TICK_DIV) == 0;
        n_cyc = m_cyc + 1;
        case (m_st)
            0: begin
                m_cmd = 0; m_tgt = 0;
                if (a) begin m_st = 1; m_ticks = 0; n_cyc = 0; end
            end
            1: begin
                if (!a) m_st = 0;
                else if (is_tick) begin
                    m_ticks++;
                    if (m_ticks == ARM_TICKS) begin m_st = 2; m_ticks = 0; m_tgt = 0; end
                end
            end
            2: begin
                if (!a) begin m_st = 0; m_cmd = 0; m_tgt = 0; end
                else begin
                    if (is_tick) m_cmd = m_cmd + clamp_step(m_tgt - m_cmd);
                    if (v) begin m_tgt = t; m_ticks = 0; end
                    else if (is_tick) begin
                        m_ticks++;
                        if (m_ticks == TIMEOUT_TICKS) begin m_st = 3; m_tgt = 0; end
                    end
                end
            end
            default: begin
                if (!a) begin m_st = 0; m_cmd = 0; m_tgt = 0; end
                else if (is_tick) m_cmd = m_cmd - ((m_cmd < STEP) ? m_cmd : STEP);
            end
        endcase
        m_cyc = n_cyc;
    endtask

    task automatic tick_clk();
        model_step(rst, arm_req, tgt_valid, int'(tgt));
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int c);
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " cmd"}, 32'(cmd), 32'(c));
        check({tag, " tgt_ready"}, 32'(tgt_ready), 32'(st == 2));
        check({tag, " armed"}, 32'(armed), 32'(st == 2));
        check({tag, " fault"}, 32'(fault), 32'(st == 3));
    endtask

    typedef struct {
        int n;
        bit arm;
        bit vld;
        int tv;
        int st;
        int c;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; arm_req = 1'b0; tgt_valid = 1'b0; tgt = '0;
        repeat (2) tick_clk();
        check_outs("reset", 0, 0);
        rst = 1'b0;

        // n cycles, arm_req, tgt_valid, tgt, expected state, expected cmd
        tbl.push_back('{1,  0, 0, 0,   0, 0});
        tbl.push_back('{1,  1, 0, 0,   1, 0});
        tbl.push_back('{11, 1, 0, 0,   1, 0});
        tbl.push_back('{1,  1, 0, 0,   2, 0});
        tbl.push_back('{1,  1, 1, 10,  2, 0});
        tbl.push_back('{3,  1, 0, 0,   2, 4});
        tbl.push_back('{4,  1, 0, 0,   2, 8});
        tbl.push_back('{1,  1, 1, 10,  2, 8});
        tbl.push_back('{3,  1, 0, 0,   2, 10});
        tbl.push_back('{4,  1, 0, 0,   2, 10});
        tbl.push_back('{1,  1, 1, 3,   2, 10});
        tbl.push_back('{3,  1, 0, 0,   2, 6});
        tbl.push_back('{4,  1, 0, 0,   2, 3});
        tbl.push_back('{1,  1, 1, 10,  2, 3});
        tbl.push_back('{3,  1, 0, 0,   2, 7});
        tbl.push_back('{4,  1, 0, 0,   2, 10});
        tbl.push_back('{11, 1, 0, 0,   2, 10});
        tbl.push_back('{1,  1, 0, 0,   3, 10});
        tbl.push_back('{4,  1, 1, 500, 3, 6});
        tbl.push_back('{4,  1, 1, 500, 3, 2});
        tbl.push_back('{4,  1, 0, 0,   3, 0});
        tbl.push_back('{4,  1, 0, 0,   3, 0});
        tbl.push_back('{1,  0, 0, 0,   0, 0});
        tbl.push_back('{1,  1, 0, 0,   1, 0});
        tbl.push_back('{8,  1, 0, 0,   1, 0});
        tbl.push_back('{1,  0, 0, 0,   0, 0});
        tbl.push_back('{1,  1, 0, 0,   1, 0});
        tbl.push_back('{11, 1, 0, 0,   1, 0});
        tbl.push_back('{1,  1, 0, 0,   2, 0});
        tbl.push_back('{1,  1, 1, 10,  2, 0});
        tbl.push_back('{3,  1, 0, 0,   2, 4});
        tbl.push_back('{4,  1, 0, 0,   2, 8});
        tbl.push_back('{4,  1, 0, 0,   2, 10});
        tbl.push_back('{1,  0, 0, 0,   0, 0});

        foreach (tbl[i]) begin
            arm_req = tbl[i].arm;
            tgt_valid = tbl[i].vld;
            tgt = CMD_BITS'(tbl[i].tv);
            repeat (tbl[i].n) tick_clk();
            check_outs($sformatf("row%0d", i), tbl[i].st, tbl[i].c);
        end
        tgt_valid = 1'b0;

        // handshake on the timeout tick: stays in RUN, watchdog restarts, old target used for that step
        arm_req = 1'b1;
        repeat (13) tick_clk();
        check_outs("hs_to enter run", 2, 0);
        repeat (19) tick_clk();
        check_outs("hs_to before", 2, 0);
        tgt_valid = 1'b1; tgt = 10'd8;
        tick_clk();
        check_outs("hs_to same tick", 2, 0);
        tgt_valid = 1'b0;
        repeat (4) tick_clk();
        check_outs("hs_to first step", 2, 4);
        repeat (15) tick_clk();
        check_outs("hs_to hold", 2, 8);
        tick_clk();
        check_outs("hs_to timeout", 3, 8);
        arm_req = 1'b0;
        tick_clk();
        check_outs("hs_to disarm", 0, 0);

        // reset mid-ramp, then a full arming period is required again
        arm_req = 1'b1;
        repeat (13) tick_clk();
        tgt_valid = 1'b1; tgt = 10'd1000;
        tick_clk();
        tgt_valid = 1'b0;
        repeat (7) tick_clk();
        check_outs("rst ramp", 2, 8);
        rst = 1'b1;
        tick_clk();
        check_outs("rst applied", 0, 0);
        rst = 1'b0;
        tick_clk();
        check_outs("rst rearm", 1, 0);
        repeat (11) tick_clk();
        check_outs("rst arming", 1, 0);
        tick_clk();
        check_outs("rst run", 2, 0);

        // randomized traffic against the reference model
        begin
            int pv = 10;
            logic [14:0] act_v;
            logic [14:0] exp_v;
            for (int k = 0; k < 4000; k++) begin
                if (k % 64 == 0) begin
                    case ($urandom_range(0, 3))
                        0: pv = 0;
                        1: pv = 2;
                        2: pv = 10;
                        default: pv = 50;
                    endcase
                end
                rst = ($urandom_range(0, 999) == 0);
                if ($urandom_range(0, 199) == 0) arm_req = !arm_req;
                if (!arm_req && $urandom_range(0, 19) == 0) arm_req = 1'b1;
                tgt_valid = ($urandom_range(0, 99) < pv);
                case ($urandom_range(0, 7))
                    0: tgt = '0;
                    1: tgt = '1;
                    default: tgt = CMD_BITS'($urandom_range(0, 1023));
                endcase
                tick_clk();
                act_v = {state, cmd, tgt_ready, armed, fault};
                exp_v = {2'(m_st), 10'(m_cmd), (m_st == 2), (m_st == 2), (m_st == 3)};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL rand cycle %0d actual st=%0d cmd=%0d rdy=%0d arm=%0d flt=%0d expected st=%0d cmd=%0d",
                             k, state, cmd, tgt_ready, armed, fault, m_st, m_cmd);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
